// File: rtl/my_mod.sv
// my_mod: frame accumulator. Folds Y input beats into an accumulator using a
// per-beat opcode and emits one registered result per frame over valid/ready.
// Optional feature: define MY_MOD_PARITY_EN to add out_parity (= ^out_data).
module my_mod #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned X     = 1,
    parameter int unsigned Y     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] foo,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MY_MOD_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam int unsigned CW = (Y > 1) ? $clog2(Y) : 1;

    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             ovf;

    logic [WIDTH-1:0] sra_c;
    logic [WIDTH-1:0] addend_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] acc_nxt_c;
    logic             carry_c;
    logic             accept_c;
    logic             last_c;

    // A new beat can enter whenever the output slot is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready;
    assign last_c   = (cnt == CW'(Y - 1));

    // Next accumulator value and carry for the beat currently presented.
    always_comb begin
        sra_c     = WIDTH'($signed(foo) >>> X);
        addend_c  = (op == 2'b11) ? sra_c : foo;
        sum_c     = {1'b0, acc} + {1'b0, addend_c};
        acc_nxt_c = acc;
        carry_c   = 1'b0;
        case (op)
            2'b00, 2'b11: begin
                acc_nxt_c = sum_c[WIDTH-1:0];
                carry_c   = sum_c[WIDTH];
            end
            2'b01:   acc_nxt_c = acc ^ foo;
            default: acc_nxt_c = acc | (foo << X);
        endcase
    end

    // Frame accumulation and beat counting; cleared on the frame's last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept_c) begin
            if (last_c) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                acc <= acc_nxt_c;
                cnt <= CW'(cnt + CW'(1));
                ovf <= ovf | carry_c;
            end
        end
    end

    // Result slot: loaded on frame end, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept_c && last_c) begin
                out_valid <= 1'b1;
                out_data  <= acc_nxt_c;
                out_ovf   <= ovf | carry_c;
            end
        end
    end

`ifdef MY_MOD_PARITY_EN
    // Parity travels with out_data under the same load/hold rules.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (accept_c && last_c) begin
            out_parity <= ^acc_nxt_c;
        end
    end
`endif

endmodule

// File: tb/tb_my_mod.sv
// tb_my_mod: directed table, hand sequences and randomized model checking of my_mod.
module tb_my_mod;

    localparam int W  = 9;
    localparam int XS = 1;
    localparam int YF = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Y=2 instance
    logic [W-1:0] foo = '0;
    logic [1:0]   op = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         out_valid;
    logic         out_ready = 1'b0;

    // Y=1 instance
    logic [W-1:0] b_foo = '0;
    logic [1:0]   b_op = '0;
    logic         b_in_valid = 1'b0;
    logic         b_in_ready;
    logic [W-1:0] b_out_data;
    logic         b_out_ovf;
    logic         b_out_valid;
    logic         b_out_ready = 1'b0;

`ifdef MY_MOD_PARITY_EN
    logic out_parity;
    logic b_out_parity;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    my_mod #(.WIDTH(W), .X(XS), .Y(YF)) dut (
        .clk(clk), .rst_n(rst_n), .foo(foo), .op(op),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ovf(out_ovf),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef MY_MOD_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    my_mod #(.WIDTH(W), .X(XS), .Y(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .foo(b_foo), .op(b_op),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_ovf(b_out_ovf),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
`ifdef MY_MOD_PARITY_EN
        , .out_parity(b_out_parity)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Present one beat to the Y=2 instance and wait (bounded) until it is accepted.
    task automatic send(input logic [1:0] o, input logic [W-1:0] d);
        int n;
        @(negedge clk);
        op = o; foo = d; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 100) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- reference model (frame semantics, integer arithmetic)
    localparam int MOD = 1 << W;
    int m_acc, m_ovf, m_cnt, m_pend, m_res, m_rovf;

    function automatic int par(input int v);
        int p = 0;
        for (int i = 0; i < W; i++) p ^= (v >> i) & 1;
        return p;
    endfunction

    task automatic model_beat(input int o, input int d);
        int s, sv, q, dv;
        dv = 1 << XS;
        case (o)
            0: begin
                s = m_acc + d;
                if (s >= MOD) m_ovf = 1;
                m_acc = s % MOD;
            end
            1: m_acc = m_acc ^ d;
            2: m_acc = m_acc | ((d * dv) % MOD);
            default: begin
                sv = (d >= MOD / 2) ? d - MOD : d;
                q = sv / dv;
                if (sv < 0 && q * dv != sv) q = q - 1;
                q = ((q % MOD) + MOD) % MOD;
                s = m_acc + q;
                if (s >= MOD) m_ovf = 1;
                m_acc = s % MOD;
            end
        endcase
        m_cnt++;
        if (m_cnt == YF) begin
            m_pend = 1; m_res = m_acc; m_rovf = m_ovf;
            m_acc = 0; m_ovf = 0; m_cnt = 0;
        end
    endtask

    typedef struct {
        logic [1:0]   op0;
        logic [W-1:0] d0;
        logic [1:0]   op1;
        logic [W-1:0] d1;
        logic [W-1:0] exp_data;
        logic         exp_ovf;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{2'b00, 9'd5,     2'b00, 9'd3,     9'd8,     1'b0};
        tbl[1] = '{2'b00, 9'd300,   2'b00, 9'd300,   9'd88,    1'b1};
        tbl[2] = '{2'b00, 9'd1,     2'b00, 9'd1,     9'd2,     1'b0};
        tbl[3] = '{2'b10, 9'd3,     2'b01, 9'd1,     9'd7,     1'b0};
        tbl[4] = '{2'b11, 9'h1FC,   2'b00, 9'd0,     9'h1FE,   1'b0};
        tbl[5] = '{2'b11, 9'h100,   2'b00, 9'd0,     9'h180,   1'b0};
        tbl[6] = '{2'b11, 9'h1FF,   2'b11, 9'h1FF,   9'h1FE,   1'b1};

        // Reset state
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_in_ready", in_ready, 1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Directed frames from the table
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].op0, tbl[i].d0);
            chk($sformatf("tbl%0d_mid_valid", i), out_valid, 0);
            send(tbl[i].op1, tbl[i].d1);
            chk($sformatf("tbl%0d_valid", i), out_valid, 1);
            chk($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_ovf", i), out_ovf, tbl[i].exp_ovf);
            chk($sformatf("tbl%0d_in_ready_bp", i), in_ready, 0);
`ifdef MY_MOD_PARITY_EN
            chk($sformatf("tbl%0d_parity", i), out_parity, par(tbl[i].exp_data));
`endif
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk($sformatf("tbl%0d_retired", i), out_valid, 0);
        end

        // Backpressure: result held, beat stalled, then retire + accept together
        send(2'b00, 9'd5);
        send(2'b00, 9'd3);
        @(negedge clk);
        op = 2'b00; foo = 9'd2; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_data", out_data, 8);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        send(2'b00, 9'd4);
        chk("bp_resume_valid", out_valid, 1);
        chk("bp_resume_data", out_data, 6);

        // Reset with a pending result
        pulse_reset();

        // Reset mid-frame discards the partial accumulation
        send(2'b00, 9'd7);
        pulse_reset();
        send(2'b00, 9'd5);
        send(2'b00, 9'd3);
        chk("post_rst_data", out_data, 8);
        chk("post_rst_valid", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Y=1: continuous full-throughput frames
        @(negedge clk);
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_op = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            b_foo = W'(k);
            @(posedge clk); #1;
            chk("y1_valid", b_out_valid, 1);
            chk("y1_data", b_out_data, k);
            chk("y1_ovf", b_out_ovf, 0);
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("y1_drain", b_out_valid, 0);

        // Randomized traffic against the reference model
        pulse_reset();
        m_acc = 0; m_ovf = 0; m_cnt = 0; m_pend = 0; m_res = 0; m_rovf = 0;
        for (int c = 0; c < 2000; c++) begin
            int exp_ready;
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            op  = 2'($urandom_range(0, 3));
            foo = W'($urandom);
            #1;
            exp_ready = (!m_pend || out_ready) ? 1 : 0;
            chk("rnd_in_ready", in_ready, exp_ready);
            @(posedge clk);
            if (m_pend != 0 && out_ready) m_pend = 0;
            if (in_valid && exp_ready != 0) model_beat(int'(op), int'(foo));
            #1;
            chk("rnd_out_valid", out_valid, m_pend);
            if (m_pend != 0) begin
                chk("rnd_out_data", out_data, m_res);
                chk("rnd_out_ovf", out_ovf, m_rovf);
`ifdef MY_MOD_PARITY_EN
                chk("rnd_parity", out_parity, par(m_res));
`endif
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
